// File: rtl/laboratories_map_loader.sv
// laboratories_map_loader
//
// Front end of the beam-timeline solver. Accepts the puzzle grid as an ASCII
// byte stream, packs each text row into a WIDTH-bit splitter bitmap (bit c set
// when column c holds '^'), and writes the rows one at a time into map storage.
// It also records the column of the 'S' entry point and flags malformed input.
//
// Optional feature macro: LOADER_SPLIT_COUNT_EN
//   defined     -> 16-bit saturating count of accepted '^' bytes on split_count
//   not defined -> split_count is tied to 0
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid     in   byte on in_data is valid
//   in_data      in   8-bit ASCII character
//   in_ready     out  loader accepts a byte (high only while loading)
//   row_we       out  one-cycle row write strobe
//   row_addr     out  row index, valid with row_we
//   row_data     out  row bitmap, valid with row_we
//   start_col    out  column of 'S', valid when start_found
//   start_found  out  'S' seen in the current load
//   done         out  all rows written without error (sticky)
//   error        out  malformed input detected (sticky)
//   err_code     out  0 none, 1 illegal char, 2 row length, 3 'S' problem
//   split_count  out  accepted '^' count (or 0, see macro above)

module laboratories_map_loader #(
  parameter int WIDTH  = 141,
  parameter int HEIGHT = 141,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              row_we,
  output logic [ADDR_W-1:0] row_addr,
  output logic [WIDTH-1:0]  row_data,
  output logic [ADDR_W-1:0] start_col,
  output logic              start_found,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       split_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] col_r;
  logic [ADDR_W-1:0] row_r;
  logic [WIDTH-1:0]  shift_r;

  logic       accept_s;
  logic       caret_s;
  logic       row_full_s;
  logic       last_row_s;
  logic [1:0] err_s;
  logic       commit_s;
  logic       shift_en_s;
  logic       take_s_s;
  logic       finish_s;

  // Byte classification: decides what the byte accepted this cycle does.
  always_comb begin
    accept_s   = in_valid && in_ready;
    caret_s    = (in_data == 8'h5E);
    row_full_s = (col_r == ADDR_W'(WIDTH));
    last_row_s = (row_r == ADDR_W'(HEIGHT - 1));
    err_s      = 2'd0;
    commit_s   = 1'b0;
    shift_en_s = 1'b0;
    take_s_s   = 1'b0;
    finish_s   = 1'b0;
    if (accept_s && (state_r == ST_LOAD)) begin
      case (in_data)
        8'h2E, 8'h5E: begin // '.' or '^'
          if (row_full_s) begin
            err_s = 2'd2;
          end else begin
            shift_en_s = 1'b1;
          end
        end
        8'h53: begin // 'S'
          if (row_full_s) begin
            err_s = 2'd2;
          end else if ((row_r == ADDR_W'(0)) && !start_found) begin
            shift_en_s = 1'b1;
            take_s_s   = 1'b1;
          end else begin
            err_s = 2'd3;
          end
        end
        8'h0D: begin // '\r' is dropped
          err_s = 2'd0;
        end
        8'h0A: begin // '\n'
          if (col_r == ADDR_W'(0)) begin
            err_s = 2'd0; // blank line
          end else if (row_full_s) begin
            commit_s = 1'b1;
            // The final row is written even when 'S' never appeared.
            if (last_row_s) begin
              if (start_found) begin
                finish_s = 1'b1;
              end else begin
                err_s = 2'd3;
              end
            end else begin
              finish_s = 1'b0;
            end
          end else begin
            err_s = 2'd2;
          end
        end
        default: begin
          err_s = 2'd1;
        end
      endcase
    end else begin
      err_s = 2'd0;
    end
  end

  // Control FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      col_r       <= '0;
      row_r       <= '0;
      shift_r     <= '0;
      in_ready    <= 1'b0;
      row_we      <= 1'b0;
      row_addr    <= '0;
      row_data    <= '0;
      start_col   <= '0;
      start_found <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      row_we <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          // Characters enter at the MSB, so after WIDTH of them the first
          // (leftmost) character sits in bit 0.
          if (shift_en_s) begin
            shift_r <= {caret_s, shift_r[WIDTH-1:1]};
            col_r   <= col_r + ADDR_W'(1);
          end
          if (take_s_s) begin
            start_found <= 1'b1;
            start_col   <= col_r;
          end
          if (commit_s) begin
            row_we   <= 1'b1;
            row_addr <= row_r;
            row_data <= shift_r;
            row_r    <= row_r + ADDR_W'(1);
            col_r    <= '0;
          end
          if (err_s != 2'd0) begin
            state_r  <= ST_ERROR;
            in_ready <= 1'b0;
            error    <= 1'b1;
            err_code <= err_s;
          end else if (finish_s) begin
            state_r  <= ST_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r     <= ST_LOAD;
            in_ready    <= 1'b1;
            col_r       <= '0;
            row_r       <= '0;
            shift_r     <= '0;
            start_col   <= '0;
            start_found <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_SPLIT_COUNT_EN
  logic [15:0] split_cnt_r;
  logic        caret_acc_s;

  // Any accepted '^' counts, including one that itself raises an error.
  always_comb begin
    caret_acc_s = accept_s && caret_s;
  end

  // Saturating splitter counter, cleared whenever a new load begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt_r <= 16'd0;
    end else if (start && (state_r != ST_LOAD)) begin
      split_cnt_r <= 16'd0;
    end else if (caret_acc_s && (split_cnt_r != 16'hFFFF)) begin
      split_cnt_r <= split_cnt_r + 16'd1;
    end else begin
      split_cnt_r <= split_cnt_r;
    end
  end

  assign split_count = split_cnt_r;
`else
  assign split_count = 16'd0;
`endif

endmodule

// File: doc/laboratories_map_loader.md
# laboratories_map_loader

Upstream stage of the day-7 beam-timeline solver. Consumes the puzzle input as an ASCII byte stream, converts each text row into a WIDTH-bit splitter bitmap, and writes the rows one at a time into the solver's map storage. It also reports the column of the `S` entry point, and flags malformed input.

## Interface
- `WIDTH`, 141, characters per grid row (excluding line terminator)
- `HEIGHT`, 141, number of grid rows
- `ADDR_W`, 8, width of row address and column indices; must satisfy 2^ADDR_W > max(WIDTH, HEIGHT)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR
- `in_valid`  in  1  byte on `in_data` is valid
- `in_data`  in  8  ASCII character
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready`
- `row_we`  out  1  one-cycle row write strobe
- `row_addr`  out  ADDR_W  row index 0..HEIGHT-1, valid with `row_we`
- `row_data`  out  WIDTH  bit c = 1 iff column c (0 = leftmost character) is `^`
- `start_col`  out  ADDR_W  column of `S`, valid when `start_found`
- `start_found`  out  1  `S` seen in the current load
- `done`  out  1  all HEIGHT rows written without error; held until next `start`/`rst`
- `error`  out  1  malformed input detected; held until next `start`/`rst`
- `err_code`  out  2  0 none, 1 illegal character, 2 row length mismatch, 3 `S` missing/duplicate/not in row 0
- `split_count`  out  16  number of `^` characters accepted (see Configuration)

## Operation
- States: IDLE, LOAD, DONE, ERROR. `rst` forces IDLE and all outputs to 0.
- `start` in IDLE/DONE/ERROR: go to LOAD and clear the column counter, row counter, shift register, `start_found`, `start_col`, `done`, `error`, `err_code` and `split_count`. `start` is ignored in LOAD.
- `in_ready` = 1 only in LOAD. Each accepted byte is fully processed in its handshake cycle, so there are no bubbles.
- Byte decode in LOAD, with `col` = characters accepted in the current row:
  - `.` → bit 0.
  - `^` → bit 1.
  - `S` → bit 0. If `row == 0` and `!start_found`, set `start_found=1` and `start_col=col`. Otherwise → ERROR, code 3.
  - `\r` → ignored.
  - `\n` with `col == 0` → ignored (blank line).
  - `\n` with `col == WIDTH` → commit the row: `row_we`, `row_addr=row`, `row_data`; then `row++` and `col=0`.
  - `\n` with `0 < col < WIDTH` → ERROR, code 2.
  - Any data character (`.`, `^` or `S`) arriving when `col == WIDTH` → ERROR, code 2.
  - Any other byte → ERROR, code 1.
- Committing row HEIGHT-1:
  - If `start_found` → DONE, `done=1`.
  - Else → ERROR, code 3. The row write is still issued.
- Bytes after DONE are not accepted (`in_ready=0`). A missing final `\n` leaves the loader in LOAD; the upstream source must terminate the last row.
- ERROR: `in_ready=0`, no further writes. `err_code` holds the first error only.

## Timing
- Registered outputs. The handshake for the `\n` that commits a row occurs in cycle k; `row_we`, `row_addr` and `row_data` are high/valid in cycle k+1 for exactly one cycle.
- `done`, or `error` with code 3, from the final commit rises in the same cycle as that row's `row_we`.
- `error` from a byte accepted in cycle k is visible in cycle k+1. `in_ready` is 0 from cycle k+1.
- `start_col`/`start_found` update in the cycle after the `S` handshake.
- Back-to-back rows: the minimum spacing between `row_we` pulses is WIDTH+1 cycles.
- Full grid at 100% `in_valid`: HEIGHT·(WIDTH+1) transfer cycles. The last `row_we` comes 1 cycle after the last transfer.
- `rst` mid-LOAD: next cycle is IDLE with all outputs 0; no partial row is written.

## Configuration
- `LOADER_SPLIT_COUNT_EN` defined:
  - A 16-bit counter increments on every accepted `^` in LOAD, including in the byte that triggers an error.
  - It saturates at 0xFFFF.
  - `split_count` shows the counter.
- Not defined: no counter logic; `split_count` is tied to 0.

## Test plan
- WIDTH=5, HEIGHT=3, stream `..S..\n.^.^.\n.....\n`:
  - Writes (0, 5'b00000), (1, 5'b01010), (2, 5'b00000).
  - `start_col=2`, `done=1` with the third `row_we`, `split_count=2` (0 without the macro).
- Same grid with CRLF endings, a blank line between rows, and random `in_valid` gaps: identical writes and results.
- WIDTH=5, stream `..S.x` → no writes, `error=1`, `err_code=1`, `in_ready=0` the cycle after `x`.
- WIDTH=5:
  - `..S.\n` → `err_code=2`.
  - `..S...` (6th data char) → `err_code=2`.
- WIDTH=5, HEIGHT=3:
  - `S...S\n` → `err_code=3` on the second `S`.
  - A grid with no `S` → all 3 rows written, then `error=1`, `err_code=3`, `done=0`.
- Assert `rst` after row 1 is written, then `start`: outputs clear, the reload starts at `row_addr=0`, and the full valid grid completes with `done=1`.
